pid_terms: RTL and testbench
============================

# pid_terms

Pipelined PID term generator that consumes the saturated error produced by the error-saturation stage. It takes a 10-bit signed `err_sat` with a valid strobe and produces registered P, I and D terms for the downstream summing/drive stage. It keeps a history queue of past errors for the derivative, and a saturating accumulator for the integral.

## Interface
Parameters:
- `D_QUEUE_DEPTH`, default 12: number of valid samples back used as `prev_err`; legal range 1..32.
- `P_COEFF`, default 6: unsigned proportional gain; legal range 0..15.
- `D_COEFF`, default 7: unsigned derivative gain; legal range 0..15.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `err_vld`  in  1: `err_sat` is valid this cycle; one sample per high cycle.
- `err_sat`  in  10: signed saturated error, range -512..511.
- `clr_integ`  in  1: synchronous clear of the integrator.
- `P_term`  out  14: signed proportional term.
- `I_term`  out  12: signed integral term.
- `D_term`  out  12: signed derivative term.
- `terms_vld`  out  1: one-cycle strobe; all terms are updated together.

## Operation
- History queue: `D_QUEUE_DEPTH` entries of 10 bits, all entries reset to 0. The queue advances only when `err_vld` is high.
  - On each valid sample, `prev_err` is the oldest entry. The new sample is then shifted in.
  - Sample k is compared against sample k-`D_QUEUE_DEPTH`; the first `D_QUEUE_DEPTH` samples compare against 0.
- D path:
  - `D_diff` = `err_sat` - `prev_err`, computed at 11-bit signed width.
  - `D_diff` is saturated to 7-bit signed: above 63 becomes 63, below -64 becomes -64.
  - `D_term` = `D_diff_sat` * `D_COEFF`, sign-extended to 12 bits. The result is exact.
- P path: `P_term` = `err_sat` * `P_COEFF`, sign-extended to 14 bits. The result is exact.
- I path:
  - A 16-bit signed accumulator adds sign-extended `err_sat` on each valid sample.
  - On overflow, it clamps to 0x7FFF (positive) or 0x8000 (negative).
  - `I_term` = accumulator[15:4].
- `clr_integ`:
  - Zeroes the accumulator on the next edge.
  - If asserted together with `err_vld`, the clear wins and the accumulator becomes 0; the sample is still pushed into the queue and still produces P and D terms.
- Samples with `err_vld` low are ignored completely: no queue shift, no accumulation, no `terms_vld`.

## Timing
- Two-stage pipeline.
  - Edge 1 (`err_vld` sampled): register `err_sat`, `D_diff_sat`, and the accumulator update; shift the queue.
  - Edge 2: register the products into `P_term`, `D_term`, `I_term`, and assert `terms_vld`.
- Latency: `terms_vld` is high exactly 2 cycles after `err_vld`. Throughput is one sample per cycle; back-to-back `err_vld` gives back-to-back `terms_vld`.
- Between strobes, the outputs hold their last values.
- Reset values: `P_term`=0, `I_term`=0, `D_term`=0, `terms_vld`=0. The queue, accumulator and pipeline registers are all 0.
- Reset mid-operation: everything clears asynchronously, and in-flight samples are discarded. The first `err_vld` after reset release behaves as the first sample.

## Configuration
- `PID_I_TERM_EN` defined: the accumulator, `clr_integ` logic and `I_term` path are built as specified.
- Not defined: no accumulator is built, `I_term` is tied to 0, and `clr_integ` is ignored. The P/D paths and all timing are unchanged.

## Structure
- Package `pid_pkg` holds:
  - Widths: `ERR_W`=10, `DDIFF_W`=7, `P_W`=14, `I_W`=12, `D_W`=12, `INTEG_W`=16.
  - Saturation limits: `DDIFF_MAX`=63, `DDIFF_MIN`=-64, `INTEG_MAX`=0x7FFF, `INTEG_MIN`=0x8000.
  - Typedefs for the signed error and term types.
- Sub-module `err_history_queue` (parameter DEPTH; ports `clk`, `rst_n`, `push`, `din`, `oldest`) implements the shift queue. All arithmetic stays in `pid_terms`.

## Test plan
- From reset, default parameters, a single `err_vld` with `err_sat`=100 -> 2 cycles later `terms_vld`=1 for one cycle, `P_term`=600, `D_term`=441 (D saturated at 63), `I_term`=6.
- From reset, `err_sat`=-512 -> `P_term`=-3072, `D_term`=-448, `I_term`=-32.
- 13 consecutive samples of 100 -> sample 13 gives `D_term`=0 (compared against sample 1), and the accumulator reads 1300 (`I_term`=81).
- 70 consecutive samples of 511 -> the accumulator clamps at 0x7FFF, `I_term`=2047, and there is no wrap. Then `clr_integ` together with `err_vld`, `err_sat`=5 -> `I_term`=0.
- `rst_n` pulsed low while `terms_vld` is pending -> `terms_vld` and all terms are 0 immediately. The next sample of 50 gives `D_term`=350, proving the queue was cleared.
- Build without `PID_I_TERM_EN` and repeat scenario 1 -> `I_term`=0, while P/D values and latency are identical.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared widths, limits and types for the PID term generator.
package pid_pkg;

    localparam int ERR_W   = 10;
    localparam int DDIFF_W = 7;
    localparam int P_W     = 14;
    localparam int I_W     = 12;
    localparam int D_W     = 12;
    localparam int INTEG_W = 16;

    localparam int DDIFF_MAX = 63;
    localparam int DDIFF_MIN = -64;
    localparam logic signed [INTEG_W-1:0] INTEG_MAX = 16'sh7FFF;
    localparam logic signed [INTEG_W-1:0] INTEG_MIN = 16'sh8000;

    typedef logic signed [ERR_W-1:0]   err_t;
    typedef logic signed [DDIFF_W-1:0] ddiff_t;
    typedef logic signed [P_W-1:0]     p_t;
    typedef logic signed [I_W-1:0]     i_t;
    typedef logic signed [D_W-1:0]     d_t;
    typedef logic signed [INTEG_W-1:0] integ_t;

    typedef struct packed {
        logic   vld;
        err_t   err;
        ddiff_t ddiff;
    } s1_t;

    function automatic ddiff_t sat_ddiff(input logic signed [ERR_W:0] d);
        if (d > DDIFF_MAX)
            return ddiff_t'(DDIFF_MAX);
        else if (d < DDIFF_MIN)
            return ddiff_t'(DDIFF_MIN);
        else
            return d[DDIFF_W-1:0];
    endfunction

endpackage

// File: rtl/err_history_queue.sv
// Shift queue of past error samples; oldest entry feeds the derivative.
module err_history_queue
    import pid_pkg::*;
#(
    parameter int DEPTH = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  err_t din,
    output err_t oldest
);

    err_t q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                q[i] <= '0;
        end else if (push) begin
            q[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                q[i] <= q[i-1];
        end
    end

    assign oldest = q[DEPTH-1];

endmodule

// File: rtl/pid_terms.sv
// Two-stage PID term generator (P, I, D) from saturated error samples.
// Integrator path is built only when PID_I_TERM_EN is defined.
module pid_terms
    import pid_pkg::*;
#(
    parameter int D_QUEUE_DEPTH = 12,
    parameter int P_COEFF       = 6,
    parameter int D_COEFF       = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  err_vld,
    input  logic signed [ERR_W-1:0] err_sat,
    input  logic                  clr_integ,
    output logic signed [P_W-1:0] P_term,
    output logic signed [I_W-1:0] I_term,
    output logic signed [D_W-1:0] D_term,
    output logic                  terms_vld
);

    err_t                    prev_err;
    logic signed [ERR_W:0]   d_diff;
    s1_t                     s1;
    i_t                      i_val;
    p_t                      p_prod;
    d_t                      d_prod;

    err_history_queue #(
        .DEPTH (D_QUEUE_DEPTH)
    ) u_hist (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (err_vld),
        .din    (err_sat),
        .oldest (prev_err)
    );

    assign d_diff = {err_sat[ERR_W-1], err_sat}
                  - {prev_err[ERR_W-1], prev_err};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
        end else begin
            s1.vld <= err_vld;
            if (err_vld) begin
                s1.err   <= err_sat;
                s1.ddiff <= sat_ddiff(d_diff);
            end
        end
    end

`ifdef PID_I_TERM_EN
    integ_t                  acc;
    integ_t                  acc_nxt;
    logic signed [INTEG_W:0] acc_sum;

    // One guard bit exposes overflow as a sign mismatch in the top two bits.
    assign acc_sum = {acc[INTEG_W-1], acc}
                   + {{(INTEG_W+1-ERR_W){err_sat[ERR_W-1]}}, err_sat};

    always_comb begin
        acc_nxt = acc_sum[INTEG_W-1:0];
        if (acc_sum[INTEG_W:INTEG_W-1] == 2'b01)
            acc_nxt = INTEG_MAX;
        else if (acc_sum[INTEG_W:INTEG_W-1] == 2'b10)
            acc_nxt = INTEG_MIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr_integ)
            acc <= '0;
        else if (err_vld)
            acc <= acc_nxt;
    end

    assign i_val = acc[INTEG_W-1:INTEG_W-I_W];
`else
    logic unused_clr;

    assign unused_clr = clr_integ;
    assign i_val      = '0;
`endif

    assign p_prod = p_t'($signed(s1.err)) * p_t'(P_COEFF);
    assign d_prod = d_t'($signed(s1.ddiff)) * d_t'(D_COEFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P_term    <= '0;
            I_term    <= '0;
            D_term    <= '0;
            terms_vld <= 1'b0;
        end else begin
            terms_vld <= s1.vld;
            if (s1.vld) begin
                P_term <= p_prod;
                I_term <= i_val;
                D_term <= d_prod;
            end
        end
    end

endmodule

// File: tb/tb_pid_terms.sv
// Self-checking bench for pid_terms: directed scenarios plus random traffic
// against a sample-list reference model.
module tb_pid_terms;

    localparam int DEPTH = 12;
    localparam int PC    = 6;
    localparam int DC    = 7;
`ifdef PID_I_TERM_EN
    localparam bit I_EN = 1'b1;
`else
    localparam bit I_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               err_vld = 1'b0;
    logic signed [9:0]  err_sat = '0;
    logic               clr_integ = 1'b0;
    logic signed [13:0] P_term;
    logic signed [11:0] I_term;
    logic signed [11:0] D_term;
    logic               terms_vld;

    pid_terms dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .err_vld   (err_vld),
        .err_sat   (err_sat),
        .clr_integ (clr_integ),
        .P_term    (P_term),
        .I_term    (I_term),
        .D_term    (D_term),
        .terms_vld (terms_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int p;
        int i;
        int d;
    } res_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   hist[$];
    res_t pipe[$];
    int   acc_m;
    bit   exp_v;
    int   exp_p, exp_i, exp_d;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    task automatic model_reset();
        hist.delete();
        pipe.delete();
        acc_m = 0;
        exp_v = 0;
        exp_p = 0;
        exp_i = 0;
        exp_d = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_vld"}, terms_vld, exp_v);
        chk({tag, "_P"}, P_term, exp_p);
        chk({tag, "_I"}, I_term, exp_i);
        chk({tag, "_D"}, D_term, exp_d);
    endtask

    // One clock: check results due now, then drive and model the new input.
    task automatic cycle(input bit v, input int e, input bit c);
        res_t r;
        int   prev;
        @(negedge clk);
        if (pipe.size() == 2) begin
            r = pipe.pop_front();
            exp_v = r.v;
            if (r.v) begin
                exp_p = r.p;
                exp_i = r.i;
                exp_d = r.d;
            end
        end
        check_outputs("cyc");
        err_vld   = v;
        err_sat   = e[9:0];
        clr_integ = c;
        r = '{v: v, p: 0, i: 0, d: 0};
        if (c)
            acc_m = 0;
        else if (v)
            acc_m = clamp(acc_m + e, -32768, 32767);
        if (v) begin
            prev = (hist.size() == DEPTH) ? hist.pop_front() : 0;
            hist.push_back(e);
            r.p = e * PC;
            r.d = clamp(e - prev, -64, 63) * DC;
            r.i = I_EN ? (acc_m >>> 4) : 0;
        end
        pipe.push_back(r);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            cycle(1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        err_vld   = 1'b0;
        clr_integ = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int e;
        model_reset();
        #12;
        check_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // single sample of 100
        cycle(1'b1, 100, 1'b0);
        idle(2);
        chk("s1_P", P_term, 600);
        chk("s1_D", D_term, 441);
        chk("s1_I", I_term, I_EN ? 6 : 0);
        idle(1);

        // single sample of -512
        do_reset();
        cycle(1'b1, -512, 1'b0);
        idle(2);
        chk("s2_P", P_term, -3072);
        chk("s2_D", D_term, -448);
        chk("s2_I", I_term, I_EN ? -32 : 0);

        // 13 samples of 100: last compares against the first
        do_reset();
        for (int k = 0; k < 13; k++)
            cycle(1'b1, 100, 1'b0);
        idle(2);
        chk("s3_D", D_term, 0);
        chk("s3_I", I_term, I_EN ? 81 : 0);

        // integrator clamp, then clear together with a sample
        do_reset();
        for (int k = 0; k < 70; k++)
            cycle(1'b1, 511, 1'b0);
        idle(2);
        chk("s4_I", I_term, I_EN ? 2047 : 0);
        cycle(1'b1, 5, 1'b1);
        idle(2);
        chk("s4_clr_I", I_term, 0);
        chk("s4_clr_P", P_term, 30);

        // reset while a sample is in flight
        cycle(1'b1, 200, 1'b0);
        do_reset();
        cycle(1'b1, 50, 1'b0);
        idle(2);
        chk("s5_D", D_term, 350);
        chk("s5_P", P_term, 300);

        // random traffic with extremes, clears and idle gaps
        for (int k = 0; k < 800; k++) begin
            case ($urandom_range(0, 7))
                0:       e = 511;
                1:       e = -512;
                default: e = int'($urandom_range(0, 1023)) - 512;
            endcase
            if (k == 400) begin
                cycle(1'b1, e, 1'b0);
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 7, e, $urandom_range(0, 29) == 0);
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
